// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Four-key push-button front end for a small core. Each raw key is brought
// into the clock domain by a two-flop synchronizer and then goes through its
// own debounce / auto-repeat state machine. Accepted presses and auto-repeat
// ticks raise sticky per-key event flags, which the core clears with ACK.
//
// Parameters
//   DB_CYCLES      : consecutive stable cycles needed to accept a level change
//   HOLD_CYCLES    : held cycles after an accepted press before auto-repeat
//   REP_CYCLES     : auto-repeat period in cycles
//   KEY_ACTIVE_LOW : 1 -> raw level 0 means pressed
//
// Ports
//   CLK      in   1  single clock, rising edge
//   RST_N    in   1  asynchronous active-low reset
//   KEYS     in   4  raw asynchronous push-button levels
//   ACK      in   1  one-cycle pulse clearing the events selected by ACK_MASK
//   ACK_MASK in   4  per-key event clear select, used only while ACK=1
//   LEVEL    out  4  debounced pressed state, 1 = pressed
//   EVENT    out  4  sticky per-key event flags (press or repeat)
//   IN_WORD  out 32  core input word {24'b0, EVENT, LEVEL}
// -----------------------------------------------------------------------------
module key_debouncer #(
  parameter int DB_CYCLES      = 50000,
  parameter int HOLD_CYCLES    = 25000000,
  parameter int REP_CYCLES     = 5000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  KEYS,
  input  logic        ACK,
  input  logic [3:0]  ACK_MASK,
  output logic [3:0]  LEVEL,
  output logic [3:0]  EVENT,
  output logic [31:0] IN_WORD
);

  // Counter only ever holds values up to (largest threshold - 1).
  localparam int MAX_AB  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > REP_CYCLES) ? MAX_AB : REP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);

  // Synchronizer flops rest at the released raw level so that leaving reset
  // never looks like a press.
  localparam logic [3:0] SYNC_RST = {4{KEY_ACTIVE_LOW}};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_DB_RELEASE = 3'd4
  } key_state_e;

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] pressed_s;
  logic [3:0] level_r;
  logic [3:0] event_r;
  logic [3:0] level_set_s;
  logic [3:0] level_clr_s;
  logic [3:0] event_set_s;
  logic [3:0] ack_clr_s;

  // Two-flop synchronizer for the raw key levels.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= SYNC_RST;
      sync2_r <= SYNC_RST;
    end else begin
      sync1_r <= KEYS;
      sync2_r <= sync1_r;
    end
  end

  // Normalise polarity so that 1 always means pressed downstream.
  assign pressed_s = KEY_ACTIVE_LOW ? ~sync2_r : sync2_r;

  // One debounce / auto-repeat machine per key.
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_state_e       state_r;
    key_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             lvl_set_s;
    logic             lvl_clr_s;
    logic             evt_set_s;
    logic             p_s;

    assign p_s = pressed_s[g];

    // State and cycle counter registers for this key.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_r <= ST_IDLE;
        cnt_r   <= CNT_ZERO;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
      end
    end

    // Next-state, counter and level/event strobes for this key. The counter
    // is cleared on every transition and at every threshold, so it never
    // wraps regardless of how long a key is held.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      lvl_set_s   = 1'b0;
      lvl_clr_s   = 1'b0;
      evt_set_s   = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (p_s) begin
            state_nxt_s = ST_DB_PRESS;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        ST_DB_PRESS: begin
          if (!p_s) begin
            // Bounce before the press was accepted: start over.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == DB_LAST) begin
            state_nxt_s = ST_HELD;
            cnt_nxt_s   = CNT_ZERO;
            lvl_set_s   = 1'b1;
            evt_set_s   = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!p_s) begin
            state_nxt_s = ST_DB_RELEASE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == HOLD_LAST) begin
            state_nxt_s = ST_REPEAT;
            cnt_nxt_s   = CNT_ZERO;
            evt_set_s   = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!p_s) begin
            state_nxt_s = ST_DB_RELEASE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == REP_LAST) begin
            cnt_nxt_s   = CNT_ZERO;
            evt_set_s   = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_DB_RELEASE: begin
          if (p_s) begin
            // Release glitch: key is still held, resume the hold phase
            // without reporting a new press.
            state_nxt_s = ST_HELD;
            cnt_nxt_s   = CNT_ZERO;
          end else if (cnt_r == DB_LAST) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            lvl_clr_s   = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end

    assign level_set_s[g] = lvl_set_s;
    assign level_clr_s[g] = lvl_clr_s;
    assign event_set_s[g] = evt_set_s;
  end

  assign ack_clr_s = ACK ? ACK_MASK : 4'b0000;

  // Debounced level and sticky event flags; a set beats a same-cycle clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level_r <= 4'b0000;
      event_r <= 4'b0000;
    end else begin
      level_r <= level_set_s | (level_r & ~level_clr_s);
      event_r <= event_set_s | (event_r & ~ack_clr_s);
    end
  end

  assign LEVEL   = level_r;
  assign EVENT   = event_r;
  assign IN_WORD = {24'h000000, event_r, level_r};

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//
// Directed scenarios followed by a random phase, all checked every cycle
// against a timing model of the key behaviour. The model reasons in terms of
// run lengths of the synchronized pressed level and elapsed time since the
// key entered its held phase, rather than in terms of machine states.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  keys;
  logic        ack;
  logic [3:0]  ack_mask;
  logic [3:0]  level;
  logic [3:0]  evt;
  logic [31:0] in_word;

  int errors;
  int checks;

  key_debouncer #(
    .DB_CYCLES      (DB),
    .HOLD_CYCLES    (HOLD),
    .REP_CYCLES     (REP),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .KEYS     (keys),
    .ACK      (ack),
    .ACK_MASK (ack_mask),
    .LEVEL    (level),
    .EVENT    (evt),
    .IN_WORD  (in_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0] m_lvl;
  logic [3:0] m_ev;
  logic [3:0] m_s1;
  logic [3:0] m_s2;
  int         m_ones[4];
  int         m_zeros[4];
  int         m_anchor[4];
  int         t;

  function automatic void model_reset();
    m_lvl = 4'b0000;
    m_ev  = 4'b0000;
    m_s1  = 4'b1111;
    m_s2  = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      m_ones[i]   = 0;
      m_zeros[i]  = 0;
      m_anchor[i] = 0;
    end
  endfunction

  // A press is accepted once DB+1 consecutive pressed samples are seen while
  // released; a release needs DB+1 consecutive released samples. While held,
  // events fire HOLD cycles after the held phase began and every REP after.
  function automatic void model_edge();
    int e;
    bit p;
    bit fire;
    t++;
    for (int i = 0; i < 4; i++) begin
      fire = 1'b0;
      p    = ~m_s2[i];
      if (!m_lvl[i]) begin
        m_ones[i] = p ? m_ones[i] + 1 : 0;
        if (m_ones[i] == DB + 1) begin
          m_lvl[i]    = 1'b1;
          fire        = 1'b1;
          m_anchor[i] = t;
          m_ones[i]   = 0;
        end
      end else if (!p) begin
        m_zeros[i]++;
        if (m_zeros[i] == DB + 1) begin
          m_lvl[i]   = 1'b0;
          m_zeros[i] = 0;
        end
      end else if (m_zeros[i] != 0) begin
        m_anchor[i] = t;
        m_zeros[i]  = 0;
      end else begin
        e = t - m_anchor[i];
        if (e >= HOLD && ((e - HOLD) % REP) == 0) fire = 1'b1;
      end
      m_ev[i] = fire | (m_ev[i] & ~(ack & ack_mask[i]));
    end
    m_s2 = m_s1;
    m_s1 = keys;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model, and compare all outputs after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    chk("level", {28'h0, level}, {28'h0, m_lvl});
    chk("event", {28'h0, evt}, {28'h0, m_ev});
    chk("in_word", in_word, {24'h0, m_ev, m_lvl});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ack_pulse(input logic [3:0] mask);
    ack      = 1'b1;
    ack_mask = mask;
    step();
    ack      = 1'b0;
    ack_mask = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    errors   = 0;
    checks   = 0;
    t        = 0;
    rst_n    = 1'b0;
    keys     = 4'b1111;
    ack      = 1'b0;
    ack_mask = 4'b0000;
    model_reset();

    // Reset state.
    steps(3);
    chk("reset_in_word", in_word, 32'h0000_0000);
    rst_n = 1'b1;
    steps(5);

    // Single key press: level/event appear 4 cycles after the FSM first
    // samples the synchronized low (7 edges after the raw change).
    keys[0] = 1'b0;
    steps(6);
    chk("k0_level_early", {28'h0, level}, 32'h0);
    step();
    chk("k0_level", {28'h0, level}, 32'h1);
    chk("k0_event", {28'h0, evt}, 32'h1);
    chk("k0_in_word", in_word, 32'h0000_0011);
    ack_pulse(4'b0001);
    keys[0] = 1'b1;
    steps(10);
    chk("k0_released", {28'h0, level}, 32'h0);

    // Short bounces never qualify.
    for (int k = 0; k < 3; k++) begin
      keys[1] = 1'b0;
      steps(3);
      keys[1] = 1'b1;
      steps(2);
    end
    steps(6);
    chk("k1_bounce_level", {28'h0, level}, 32'h0);
    chk("k1_bounce_event", {28'h0, evt}, 32'h0);

    // Auto-repeat timing: press, +HOLD, then every REP.
    keys[2] = 1'b0;
    n = 0;
    do begin step(); n++; end while (!evt[2] && n < 40);
    chk("k2_press_latency", n, 7);
    for (int k = 0; k < 3; k++) begin
      ack_pulse(4'b0100);
      chk("k2_cleared", {31'h0, evt[2]}, 32'h0);
      n = 1;
      while (!evt[2] && n < 40) begin step(); n++; end
      chk("k2_repeat_gap", n, (k == 0) ? HOLD : REP);
    end
    keys[2] = 1'b1;
    steps(10);
    ack_pulse(4'b1111);

    // Release glitch on a held key: level stays, no extra event.
    keys[0] = 1'b0;
    steps(7);
    ack_pulse(4'b0001);
    keys[0] = 1'b1;
    step();
    keys[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("glitch_level", {31'h0, level[0]}, 32'h1);
      chk("glitch_event", {31'h0, evt[0]}, 32'h0);
    end
    keys[0] = 1'b1;
    steps(10);

    // ACK of all bits in the same cycle a key-3 press completes: set wins.
    keys[0] = 1'b0;
    steps(7);
    keys[0] = 1'b1;
    steps(10);
    chk("pre_ack_event", {28'h0, evt}, 32'h1);
    keys[3] = 1'b0;
    steps(6);
    ack_pulse(4'b1111);
    chk("set_wins_event", {28'h0, evt}, 32'h8);
    keys[3] = 1'b1;
    steps(10);
    ack_pulse(4'b1111);

    // Reset during auto-repeat with the key held, then a fresh press.
    keys[1] = 1'b0;
    steps(22);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_in_word", in_word, 32'h0000_0000);
    steps(2);
    rst_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!evt[1] && n < 40);
    chk("post_reset_press", n, 7);
    chk("post_reset_level", {28'h0, level}, 32'h2);
    keys[1] = 1'b1;
    steps(10);

    // Random phase.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) keys[i] = ~keys[i];
      end
      ack      = ($urandom_range(0, 3) == 0);
      ack_mask = 4'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
